// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet generator blocks.
package pkt_gen_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int EMPTY_WIDTH    = 3;
  localparam int PKT_SIZE_WIDTH = 16;
  localparam logic [7:0] HDR_MARKER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } builder_state_t;

  typedef struct packed {
    logic [7:0]                marker;
    logic [7:0]                flow;
    logic [PKT_SIZE_WIDTH-1:0] size;
    logic [31:0]               seq;
  } pkt_hdr_t;

endpackage

// File: rtl/pkt_gen_flow_seq_ram.sv
// Per-flow 32-bit sequence counters: combinational read, increment of the
// addressed entry when inc_i is set, synchronous clear on reset.
module pkt_gen_flow_seq_ram #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] addr_i,
  input  logic                      inc_i,
  output logic [31:0]               rd_data_o
);

  logic [31:0] cnt_q [FLOW_CNT];
  logic        addr_ok;

  // Out-of-range addresses read as zero and are never written.
  always_comb begin
    addr_ok   = ({1'b0, addr_i} < (FLOW_CNT_WIDTH + 1)'(FLOW_CNT));
    rd_data_o = addr_ok ? cnt_q[addr_i] : 32'd0;
  end

  // Clear all counters on reset; otherwise bump the addressed one (wraps).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) cnt_q[i] <= 32'd0;
    end else if (inc_i && addr_ok) begin
      cnt_q[addr_i] <= rd_data_o + 32'd1;
    end
  end

endmodule

// File: rtl/pkt_gen_pkt_builder.sv
// Turns one (flow, size) task into a 64-bit stream packet: a header word
// followed by word-index payload words, with per-flow sequence numbers.
module pkt_gen_pkt_builder
  import pkt_gen_pkg::*;
#(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int MIN_PKT_SIZE   = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] task_flow_num_i,
  input  logic [PKT_SIZE_WIDTH-1:0] task_pkt_size_i,
  input  logic                      task_valid_i,
  output logic                      task_ready_o,
  output logic [DATA_WIDTH-1:0]     pkt_data_o,
  output logic                      pkt_sop_o,
  output logic                      pkt_eop_o,
  output logic [EMPTY_WIDTH-1:0]    pkt_empty_o,
  output logic                      pkt_valid_o,
  input  logic                      pkt_ready_i,
  output logic [31:0]               pkt_cnt_o,
  output logic [31:0]               drop_cnt_o
);

  localparam int WORD_CNT_WIDTH = 13;

  function automatic logic [PKT_SIZE_WIDTH-1:0] eff_size(input logic [PKT_SIZE_WIDTH-1:0] sz);
    logic [PKT_SIZE_WIDTH-1:0] min_sz;
    min_sz = PKT_SIZE_WIDTH'(MIN_PKT_SIZE);
    return (sz < min_sz) ? min_sz : sz;
  endfunction

  // Index of the last word: ceil(size/8) - 1 == (size-1) >> 3.
  function automatic logic [WORD_CNT_WIDTH-1:0] last_word(input logic [PKT_SIZE_WIDTH-1:0] sz);
    logic [PKT_SIZE_WIDTH-1:0] m1;
    m1 = sz - PKT_SIZE_WIDTH'(1);
    return WORD_CNT_WIDTH'(m1 >> 3);
  endfunction

  // Unused bytes in the last word; a multiple of 8 wraps to 0.
  function automatic logic [EMPTY_WIDTH-1:0] empty_bytes(input logic [PKT_SIZE_WIDTH-1:0] sz);
    return EMPTY_WIDTH'(BYTES_PER_WORD - int'(sz[EMPTY_WIDTH-1:0]));
  endfunction

  builder_state_t              state_q, state_d;
  logic                        task_ready_q, task_ready_d;
  logic [FLOW_CNT_WIDTH-1:0]   flow_q, flow_d;
  logic [PKT_SIZE_WIDTH-1:0]   size_q, size_d;
  logic [31:0]                 hdr_seq_q, hdr_seq_d;
  logic [WORD_CNT_WIDTH-1:0]   word_q, word_d;
  logic [WORD_CNT_WIDTH-1:0]   last_q, last_d;
  logic [31:0]                 pkt_cnt_q, pkt_cnt_d;
  logic [31:0]                 drop_cnt_q, drop_cnt_d;

  logic                        accept;
  logic                        flow_ok;
  logic [31:0]                 seq_rd;
  logic [PKT_SIZE_WIDTH-1:0]   task_eff;
  pkt_hdr_t                    hdr;

  assign accept   = task_valid_i && task_ready_q;
  assign flow_ok  = ({1'b0, task_flow_num_i} < (FLOW_CNT_WIDTH + 1)'(FLOW_CNT));
  assign task_eff = eff_size(task_pkt_size_i);

  pkt_gen_flow_seq_ram #(
    .FLOW_CNT       (FLOW_CNT),
    .FLOW_CNT_WIDTH (FLOW_CNT_WIDTH)
  ) u_seq_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (task_flow_num_i),
    .inc_i     (accept && flow_ok),
    .rd_data_o (seq_rd)
  );

  // Next-state logic: task capture, word stepping on handshake, counters.
  always_comb begin
    state_d    = state_q;
    flow_d     = flow_q;
    size_d     = size_q;
    hdr_seq_d  = hdr_seq_q;
    word_d     = word_q;
    last_d     = last_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (flow_ok) begin
            state_d   = HDR;
            flow_d    = task_flow_num_i;
            size_d    = task_eff;
            hdr_seq_d = seq_rd;
            word_d    = WORD_CNT_WIDTH'(1);
            last_d    = last_word(task_eff);
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end
        end
      end
      HDR: begin
        if (pkt_ready_i) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (pkt_ready_i) begin
          if (word_q == last_q) begin
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            word_d = word_q + WORD_CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    task_ready_d = (state_d == IDLE);
  end

  // Control state and counters take reset; packet fields are only observed
  // outside IDLE, so they are simply loaded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      task_ready_q <= 1'b0;
      pkt_cnt_q    <= 32'd0;
      drop_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      task_ready_q <= task_ready_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
    flow_q    <= flow_d;
    size_q    <= size_d;
    hdr_seq_q <= hdr_seq_d;
    word_q    <= word_d;
    last_q    <= last_d;
  end

  // Stream outputs decoded from registered state only, so they hold under stall.
  always_comb begin
    hdr         = '{marker: HDR_MARKER, flow: 8'(flow_q), size: size_q, seq: hdr_seq_q};
    pkt_valid_o = 1'b0;
    pkt_sop_o   = 1'b0;
    pkt_eop_o   = 1'b0;
    pkt_empty_o = '0;
    pkt_data_o  = '0;
    case (state_q)
      HDR: begin
        pkt_valid_o = 1'b1;
        pkt_sop_o   = 1'b1;
        pkt_data_o  = hdr;
      end
      PAYLOAD: begin
        pkt_valid_o = 1'b1;
        pkt_data_o  = {4{16'(word_q)}};
        if (word_q == last_q) begin
          pkt_eop_o   = 1'b1;
          pkt_empty_o = empty_bytes(size_q);
        end
      end
      default: ;
    endcase
  end

  assign task_ready_o = task_ready_q;
  assign pkt_cnt_o    = pkt_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_gen_pkt_builder.sv
// Scoreboard bench for pkt_gen_pkt_builder with a 12-flow instance.
module tb_pkt_gen_pkt_builder;

  localparam int NFLOW = 12;
  localparam int FW    = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [FW-1:0] task_flow_num_i;
  logic [15:0]   task_pkt_size_i;
  logic          task_valid_i;
  logic          task_ready_o;
  logic [63:0]   pkt_data_o;
  logic          pkt_sop_o, pkt_eop_o, pkt_valid_o, pkt_ready_i;
  logic [2:0]    pkt_empty_o;
  logic [31:0]   pkt_cnt_o, drop_cnt_o;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  emp;
  } word_t;

  word_t       exp_q[$];
  int unsigned seq_m[NFLOW];
  int unsigned exp_pkts;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pkt_gen_pkt_builder #(
    .FLOW_CNT     (NFLOW),
    .MIN_PKT_SIZE (64)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .task_flow_num_i (task_flow_num_i),
    .task_pkt_size_i (task_pkt_size_i),
    .task_valid_i    (task_valid_i),
    .task_ready_o    (task_ready_o),
    .pkt_data_o      (pkt_data_o),
    .pkt_sop_o       (pkt_sop_o),
    .pkt_eop_o       (pkt_eop_o),
    .pkt_empty_o     (pkt_empty_o),
    .pkt_valid_o     (pkt_valid_o),
    .pkt_ready_i     (pkt_ready_i),
    .pkt_cnt_o       (pkt_cnt_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Build the expected word sequence for one accepted good-flow task.
  task automatic push_pkt(input int flow, input int size);
    int    eff, nw;
    word_t w;
    eff   = (size < 64) ? 64 : size;
    nw    = (eff + 7) / 8;
    w.d   = {8'hA5, 8'(flow), 16'(eff), 32'(seq_m[flow])};
    w.sop = 1'b1; w.eop = 1'b0; w.emp = 3'd0;
    exp_q.push_back(w);
    for (int k = 1; k < nw; k++) begin
      w.d   = {4{16'(k)}};
      w.sop = 1'b0;
      w.eop = (k == nw - 1);
      w.emp = w.eop ? 3'((8 - eff % 8) % 8) : 3'd0;
      exp_q.push_back(w);
    end
    seq_m[flow] = seq_m[flow] + 1;
    exp_pkts++;
  endtask

  task automatic send_task(input int flow, input int size);
    int n = 0;
    while (!task_ready_o && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("task_ready_wait", task_ready_o, 1'b1);
    task_flow_num_i = FW'(flow);
    task_pkt_size_i = 16'(size);
    task_valid_i    = 1'b1;
    if (flow < NFLOW) push_pkt(flow, size);
    @(posedge clk); #1;
    task_valid_i = 1'b0;
  endtask

  // Run until the scoreboard is empty; optionally stall with 1,0,0,1,0,1.
  task automatic drain(input bit stall);
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int n = 0;
    while ((exp_q.size() != 0 || pkt_valid_o) && n < 20000) begin
      pkt_ready_i = stall ? pat[n % 6] : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    pkt_ready_i = 1'b1;
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    chk("pkt_cnt", pkt_cnt_o, exp_pkts);
    @(posedge clk); #1;
    chk("ready_after_pkt", task_ready_o, 1'b1);
  endtask

  // Compare every presented word with the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst_i && pkt_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", pkt_data_o, 64'd0);
      end else begin
        chk("data",  pkt_data_o,  exp_q[0].d);
        chk("sop",   pkt_sop_o,   exp_q[0].sop);
        chk("eop",   pkt_eop_o,   exp_q[0].eop);
        chk("empty", pkt_empty_o, exp_q[0].emp);
        chk("ready_in_pkt", task_ready_o, 1'b0);
        if (pkt_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_i           = 1'b1;
    task_flow_num_i = '0;
    task_pkt_size_i = '0;
    task_valid_i    = 1'b0;
    pkt_ready_i     = 1'b1;
    exp_pkts        = 0;
    for (int i = 0; i < NFLOW; i++) seq_m[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  task_ready_o, 1'b0);
    chk("rst_valid",  pkt_valid_o,  1'b0);
    chk("rst_sop",    pkt_sop_o,    1'b0);
    chk("rst_eop",    pkt_eop_o,    1'b0);
    chk("rst_empty",  pkt_empty_o,  3'd0);
    chk("rst_data",   pkt_data_o,   64'd0);
    chk("rst_pktcnt", pkt_cnt_o,    32'd0);
    chk("rst_drop",   drop_cnt_o,   32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", task_ready_o, 1'b1);

    // Minimum packet on flow 0.
    send_task(0, 64);
    chk("hdr_literal", pkt_data_o, 64'hA500_0040_0000_0000);
    drain(1'b0);

    // Flow 1, size 100, twice back to back: seq 0 then 1, empty 4.
    send_task(1, 100);
    send_task(1, 100);
    drain(1'b0);

    // Padding of short and zero sizes; an odd size with empty 7.
    send_task(2, 20);
    drain(1'b0);
    send_task(2, 0);
    drain(1'b0);
    send_task(3, 65);
    drain(1'b0);

    // Backpressure on a 13-word packet.
    send_task(0, 100);
    drain(1'b1);

    // Reset while word 3 is on the bus.
    send_task(0, 100);
    repeat (3) @(posedge clk);
    #1;
    chk("word3_before_rst", pkt_data_o, 64'h0003_0003_0003_0003);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid",  pkt_valid_o,  1'b0);
    chk("midrst_ready",  task_ready_o, 1'b0);
    chk("midrst_pktcnt", pkt_cnt_o,    32'd0);
    exp_q.delete();
    exp_pkts = 0;
    for (int i = 0; i < NFLOW; i++) seq_m[i] = 0;
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Bad flow number: swallowed, counted, builder stays idle.
    send_task(13, 64);
    chk("drop_cnt",     drop_cnt_o,   32'd1);
    chk("drop_ready",   task_ready_o, 1'b1);
    chk("drop_novalid", pkt_valid_o,  1'b0);
    @(posedge clk); #1;
    chk("drop_novalid2", pkt_valid_o, 1'b0);

    // Flows 0, 5, 0 after reset: seq 0, 0, 1.
    send_task(0, 64);
    chk("post_rst_seq_f0", pkt_data_o[31:0], 32'd0);
    drain(1'b0);
    send_task(5, 64);
    chk("seq_f5", pkt_data_o[31:0], 32'd0);
    drain(1'b0);
    send_task(0, 64);
    chk("seq_f0_second", pkt_data_o[31:0], 32'd1);
    drain(1'b0);
    chk("drop_final", drop_cnt_o, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
